// File: rtl/soil_moisture_fsm_seq.sv
// -----------------------------------------------------------------------------
// soil_moisture_fsm_seq
//
// Sequential half of the soil-moisture controller. Owns the IDLE / MEASURE /
// CONTROL state register, the sample-interval timer, the ADC request/response
// handshake and the hysteresis decision that produces moisture_low. A separate
// combinational stage downstream turns current_state + moisture_low into the
// pump drive (pump on only in CONTROL with moisture_low=1).
//
// Ports
//   clk           in   1      system clock, rising edge
//   rst_n         in   1      synchronous active-low reset
//   enable        in   1      1 = run the measurement cycle, 0 = force IDLE
//   threshold     in   ADC_W  dry threshold, used only when a sample is accepted
//   adc_data      in   ADC_W  ADC result, qualified by adc_valid
//   adc_valid     in   1      one-cycle strobe qualifying adc_data
//   adc_start     out  1      one-cycle conversion request (first MEASURE cycle)
//   current_state out  2      00 IDLE, 01 MEASURE, 10 CONTROL
//   moisture_low  out  1      1 = soil dry (request watering)
//   adc_timeout   out  1      sticky: an ADC request went unanswered
//   last_sample   out  ADC_W  most recently accepted adc_data
//
// Every output comes straight from a register; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module soil_moisture_fsm_seq #(
  parameter int ADC_W           = 10,
  parameter int SAMPLE_INTERVAL = 1000,
  parameter int ADC_TIMEOUT     = 64,
  parameter int CONTROL_CYCLES  = 500,
  parameter int HYST            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] threshold,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic             adc_start,
  output logic [1:0]       current_state,
  output logic             moisture_low,
  output logic             adc_timeout,
  output logic [ADC_W-1:0] last_sample
);

  // Counter widths. CONTROL_CYCLES may be 1, so its width is taken from
  // CONTROL_CYCLES+1 to keep it at least one bit wide.
  localparam int IDLE_W = $clog2(SAMPLE_INTERVAL);
  localparam int TMO_W  = $clog2(ADC_TIMEOUT);
  localparam int CTRL_W = $clog2(CONTROL_CYCLES + 1);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SAMPLE_INTERVAL - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ADC_TIMEOUT - 1);
  localparam logic [CTRL_W-1:0] CTRL_LAST = CTRL_W'(CONTROL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_MEASURE = 2'b01,
    S_CONTROL = 2'b10
  } state_t;

  state_t             r_state;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [TMO_W-1:0]   r_wait_cnt;
  logic [CTRL_W-1:0]  r_ctrl_cnt;
  logic               r_adc_start;
  logic               r_moisture_low;
  logic               r_adc_timeout;
  logic [ADC_W-1:0]   r_last_sample;

  state_t             w_state_nxt;
  logic [IDLE_W-1:0]  w_idle_cnt_nxt;
  logic [TMO_W-1:0]   w_wait_cnt_nxt;
  logic [CTRL_W-1:0]  w_ctrl_cnt_nxt;
  logic               w_adc_start_nxt;
  logic               w_moisture_low_nxt;
  logic               w_adc_timeout_nxt;
  logic [ADC_W-1:0]   w_last_sample_nxt;
  logic               w_accept;

  // Hysteresis decision for one accepted sample.
  //   data <  thr        -> dry (1)
  //   data >= thr + HYST -> wet (0)
  //   otherwise          -> keep previous decision
  // The upper bound is formed one bit wider than the sample, so a threshold
  // near full scale cannot wrap into a small value; when the bound is above
  // the largest representable sample the "wet" branch is simply never taken.
  function automatic logic hyst_update(input logic [ADC_W-1:0] data,
                                       input logic [ADC_W-1:0] thr,
                                       input logic             prev);
    logic [ADC_W:0] upper;
    upper = {1'b0, thr} + (ADC_W+1)'(HYST);
    if (data < thr) begin
      hyst_update = 1'b1;
    end else if ({1'b0, data} >= upper) begin
      hyst_update = 1'b0;
    end else begin
      hyst_update = prev;
    end
  endfunction

  // A reply is only taken after the request cycle: r_adc_start is high in
  // exactly the first MEASURE cycle, which is when the ADC cannot have
  // answered yet.
  assign w_accept = (r_state == S_MEASURE) && adc_valid && !r_adc_start;

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt        = r_state;
    w_idle_cnt_nxt     = r_idle_cnt;
    w_wait_cnt_nxt     = r_wait_cnt;
    w_ctrl_cnt_nxt     = r_ctrl_cnt;
    w_adc_start_nxt    = 1'b0;
    w_moisture_low_nxt = r_moisture_low;
    w_adc_timeout_nxt  = r_adc_timeout;
    w_last_sample_nxt  = r_last_sample;

    if (!enable) begin
      // Disabled: park in IDLE with the timers cleared and the pump request
      // withdrawn. The timeout flag and last sample are kept for inspection.
      w_state_nxt        = S_IDLE;
      w_idle_cnt_nxt     = '0;
      w_wait_cnt_nxt     = '0;
      w_ctrl_cnt_nxt     = '0;
      w_moisture_low_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_idle_cnt == IDLE_LAST) begin
            w_state_nxt     = S_MEASURE;
            w_idle_cnt_nxt  = '0;
            w_wait_cnt_nxt  = '0;
            w_adc_start_nxt = 1'b1;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
          end
        end

        S_MEASURE: begin
          // Accept is checked before timeout so a reply on the last allowed
          // cycle still counts.
          if (w_accept) begin
            w_state_nxt        = S_CONTROL;
            w_wait_cnt_nxt     = '0;
            w_ctrl_cnt_nxt     = '0;
            w_last_sample_nxt  = adc_data;
            w_moisture_low_nxt = hyst_update(adc_data, threshold, r_moisture_low);
          end else if (r_wait_cnt == TMO_LAST) begin
            // Dead sensor: give up, flag it, and make sure the pump stays off.
            w_state_nxt        = S_IDLE;
            w_wait_cnt_nxt     = '0;
            w_adc_timeout_nxt  = 1'b1;
            w_moisture_low_nxt = 1'b0;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end

        S_CONTROL: begin
          // moisture_low is deliberately left untouched for the whole window.
          if (r_ctrl_cnt == CTRL_LAST) begin
            w_state_nxt    = S_IDLE;
            w_ctrl_cnt_nxt = '0;
          end else begin
            w_ctrl_cnt_nxt = r_ctrl_cnt + 1'b1;
          end
        end

        default: begin
          // Encoding 11 is unreachable; recover to a clean IDLE.
          w_state_nxt    = S_IDLE;
          w_idle_cnt_nxt = '0;
          w_wait_cnt_nxt = '0;
          w_ctrl_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_idle_cnt     <= '0;
      r_wait_cnt     <= '0;
      r_ctrl_cnt     <= '0;
      r_adc_start    <= 1'b0;
      r_moisture_low <= 1'b0;
      r_adc_timeout  <= 1'b0;
      r_last_sample  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_idle_cnt     <= w_idle_cnt_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
      r_ctrl_cnt     <= w_ctrl_cnt_nxt;
      r_adc_start    <= w_adc_start_nxt;
      r_moisture_low <= w_moisture_low_nxt;
      r_adc_timeout  <= w_adc_timeout_nxt;
      r_last_sample  <= w_last_sample_nxt;
    end
  end

  assign current_state = r_state;
  assign adc_start     = r_adc_start;
  assign moisture_low  = r_moisture_low;
  assign adc_timeout   = r_adc_timeout;
  assign last_sample   = r_last_sample;

endmodule
